// File: rtl/cache_pkg.sv
// Shared widths, mode encodings, FSM states and way-mask helpers for the
// cache lookup controller.
package cache_pkg;

    localparam int WIDTH = 32;
    localparam int WAYS  = 8;
    localparam int TAG_W = 19;
    localparam int IDX_W = 12;
    localparam int WAY_W = 3;

    typedef enum logic [1:0] {
        MODE_DM   = 2'b00,
        MODE_2WAY = 2'b01,
        MODE_4WAY = 2'b10,
        MODE_8WAY = 2'b11
    } mode_e;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        COMPARE,
        MEM_REQ,
        MEM_WAIT,
        TAG_WR,
        RESP
    } state_e;

    function automatic logic [WAYS-1:0] way_mask(input logic [1:0] mode);
        case (mode)
            MODE_DM:   return 8'h01;
            MODE_2WAY: return 8'h03;
            MODE_4WAY: return 8'h0F;
            default:   return 8'hFF;
        endcase
    endfunction

    // Mask applied to the round-robin pointer: enabled way count minus one.
    function automatic logic [WAY_W-1:0] ptr_mask(input logic [1:0] mode);
        return {&mode, mode[1], |mode};
    endfunction

endpackage

// File: rtl/cache_lookup_ctrl_if.sv
// CPU, tag RAM and refill-port signals of the lookup controller.
// master = the controller, slave = the CPU/tag RAM/memory environment.
interface cache_lookup_ctrl_if;
    import cache_pkg::*;

    logic [1:0]            mode;
    logic                  cpu_req_valid;
    logic                  cpu_req_ready;
    logic [WIDTH-1:0]      cpu_addr;
    logic                  cpu_resp_valid;
    logic                  cpu_resp_hit;
    logic [WAY_W-1:0]      cpu_resp_way;
    logic                  tag_rd_en;
    logic [IDX_W-1:0]      tag_rd_index;
    logic [WAYS*TAG_W-1:0] tag_rd_tag;
    logic [WAYS-1:0]       tag_rd_vld;
    logic                  tag_wr_en;
    logic [WAY_W-1:0]      tag_wr_way;
    logic [IDX_W-1:0]      tag_wr_index;
    logic [TAG_W-1:0]      tag_wr_tag;
    logic                  mem_req_valid;
    logic                  mem_req_ready;
    logic [WIDTH-1:0]      mem_req_addr;
    logic                  mem_rsp_valid;

    modport master (
        input  mode, cpu_req_valid, cpu_addr, tag_rd_tag, tag_rd_vld,
               mem_req_ready, mem_rsp_valid,
        output cpu_req_ready, cpu_resp_valid, cpu_resp_hit, cpu_resp_way,
               tag_rd_en, tag_rd_index, tag_wr_en, tag_wr_way, tag_wr_index,
               tag_wr_tag, mem_req_valid, mem_req_addr
    );

    modport slave (
        output mode, cpu_req_valid, cpu_addr, tag_rd_tag, tag_rd_vld,
               mem_req_ready, mem_rsp_valid,
        input  cpu_req_ready, cpu_resp_valid, cpu_resp_hit, cpu_resp_way,
               tag_rd_en, tag_rd_index, tag_wr_en, tag_wr_way, tag_wr_index,
               tag_wr_tag, mem_req_valid, mem_req_addr
    );

endinterface

// File: rtl/cache_addr_decode.sv
// Combinational split of a line address into tag RAM index, stored tag and
// enabled-way mask for the selected associativity.
module cache_addr_decode
    import cache_pkg::*;
(
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:4] line_addr,
    output logic [IDX_W-1:0] index,
    output logic [TAG_W-1:0] tag,
    output logic [WAYS-1:0]  ways
);

    // Each doubling of associativity moves one index bit into the tag.
    always_comb begin
        index = '0;
        tag   = '0;
        case (mode)
            MODE_DM: begin
                index = line_addr[15:4];
                tag   = {3'b0, line_addr[31:16]};
            end
            MODE_2WAY: begin
                index = {1'b0, line_addr[14:4]};
                tag   = {2'b0, line_addr[31:15]};
            end
            MODE_4WAY: begin
                index = {2'b0, line_addr[13:4]};
                tag   = {1'b0, line_addr[31:14]};
            end
            default: begin
                index = {3'b0, line_addr[12:4]};
                tag   = line_addr[31:13];
            end
        endcase
    end

    assign ways = way_mask(mode);

endmodule

// File: rtl/cache_lookup_ctrl.sv
// Sequences a single CPU access through tag read, way compare, victim choice,
// line refill and tag write-back. One access in flight at a time.
module cache_lookup_ctrl
    import cache_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    cache_lookup_ctrl_if.master bus
);

    state_e           state, state_next;
    logic [WIDTH-1:4] line_q;
    logic [1:0]       mode_q;
    logic [WAY_W-1:0] rr_ptr;
    logic [WAY_W-1:0] victim_q;
    logic             from_rr_q;
    logic             resp_hit_q;
    logic [WAY_W-1:0] resp_way_q;

    logic [IDX_W-1:0] index;
    logic [TAG_W-1:0] tag;
    logic [WAYS-1:0]  ways;

    logic             hit;
    logic [WAY_W-1:0] hit_way;
    logic [WAY_W-1:0] victim_way;
    logic             victim_from_rr;
    logic             unused_offset;

    assign unused_offset = ^bus.cpu_addr[3:0];

    cache_addr_decode u_decode (
        .mode      (mode_q),
        .line_addr (line_q),
        .index     (index),
        .tag       (tag),
        .ways      (ways)
    );

    // Scanning downwards lets the lowest-numbered hit / invalid way win.
    always_comb begin
        hit            = 1'b0;
        hit_way        = '0;
        victim_way     = rr_ptr & ptr_mask(mode_q);
        victim_from_rr = 1'b1;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (ways[w] && bus.tag_rd_vld[w] &&
                bus.tag_rd_tag[w*TAG_W +: TAG_W] == tag) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
            if (ways[w] && !bus.tag_rd_vld[w]) begin
                victim_way     = WAY_W'(w);
                victim_from_rr = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next         = state;
        bus.cpu_req_ready  = 1'b0;
        bus.tag_rd_en      = 1'b0;
        bus.tag_wr_en      = 1'b0;
        bus.mem_req_valid  = 1'b0;
        bus.cpu_resp_valid = 1'b0;
        unique case (state)
            IDLE: begin
                bus.cpu_req_ready = 1'b1;
                if (bus.cpu_req_valid) state_next = LOOKUP;
            end
            LOOKUP: begin
                bus.tag_rd_en = 1'b1;
                state_next    = COMPARE;
            end
            COMPARE: begin
                state_next = hit ? RESP : MEM_REQ;
            end
            MEM_REQ: begin
                bus.mem_req_valid = 1'b1;
                if (bus.mem_req_ready) state_next = MEM_WAIT;
            end
            MEM_WAIT: begin
                if (bus.mem_rsp_valid) state_next = TAG_WR;
            end
            TAG_WR: begin
                bus.tag_wr_en = 1'b1;
                state_next    = RESP;
            end
            RESP: begin
                bus.cpu_resp_valid = 1'b1;
                state_next         = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Response fields change only on the edge into RESP, so they hold between responses.
    always_ff @(posedge clk) begin
        if (!reset) begin
            line_q     <= '0;
            mode_q     <= '0;
            rr_ptr     <= '0;
            victim_q   <= '0;
            from_rr_q  <= 1'b0;
            resp_hit_q <= 1'b0;
            resp_way_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.cpu_req_valid) begin
                        line_q <= bus.cpu_addr[WIDTH-1:4];
                        mode_q <= bus.mode;
                    end
                end
                COMPARE: begin
                    if (hit) begin
                        resp_hit_q <= 1'b1;
                        resp_way_q <= hit_way;
                    end else begin
                        victim_q  <= victim_way;
                        from_rr_q <= victim_from_rr;
                    end
                end
                TAG_WR: begin
                    resp_hit_q <= 1'b0;
                    resp_way_q <= victim_q;
                    if (from_rr_q) rr_ptr <= (rr_ptr + 3'd1) & ptr_mask(mode_q);
                end
                default: ;
            endcase
        end
    end

    assign bus.cpu_resp_hit = resp_hit_q;
    assign bus.cpu_resp_way = resp_way_q;
    assign bus.tag_rd_index = index;
    assign bus.tag_wr_index = index;
    assign bus.tag_wr_tag   = tag;
    assign bus.tag_wr_way   = victim_q;
    assign bus.mem_req_addr = {line_q, 4'b0};

endmodule

// File: tb/tb_cache_lookup_ctrl.sv
// Directed and randomized accesses against a behavioural model of the lookup
// controller; the bench plays CPU, tag RAM and refill memory.
module tb_cache_lookup_ctrl;
    import cache_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   vectors = 0;
    int   miscompares = 0;
    int   rr_model = 0;

    cache_lookup_ctrl_if bus ();

    cache_lookup_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", name, observed, expected);
        end
    endtask

    function automatic logic [31:0] model_index(input logic [1:0] m, input logic [31:0] a);
        return (a >> 4) % (32'h1000 >> m);
    endfunction

    function automatic logic [31:0] model_tag(input logic [1:0] m, input logic [31:0] a);
        return a >> (16 - m);
    endfunction

    // One complete access; the model outcome is worked out before the request is driven.
    task automatic applyStimulus(input logic [1:0] m, input logic [31:0] a,
                                 input logic [151:0] tags, input logic [7:0] vld,
                                 input int rdy_delay, input int rsp_delay,
                                 input bit stray, input bit abort);
        int          n;
        int          hit_way;
        int          victim;
        bit          from_rr;
        logic [31:0] idx;
        logic [31:0] tg;

        n   = 1 << m;
        idx = model_index(m, a);
        tg  = model_tag(m, a);
        hit_way = -1;
        victim  = -1;
        for (int w = 0; w < n; w++) begin
            if (hit_way < 0 && vld[w] && 32'(tags[19*w +: 19]) == tg) hit_way = w;
            if (victim < 0 && !vld[w]) victim = w;
        end
        from_rr = (victim < 0);
        if (from_rr) victim = rr_model % n;

        @(negedge clk);
        checkOutput("idle_ready", 32'(bus.cpu_req_ready), 1);
        checkOutput("idle_no_resp", 32'(bus.cpu_resp_valid), 0);
        bus.cpu_req_valid = 1'b1;
        bus.mode          = m;
        bus.cpu_addr      = a;
        bus.tag_rd_tag    = tags;
        bus.tag_rd_vld    = vld;

        @(negedge clk);
        bus.cpu_req_valid = 1'b0;
        bus.mode          = 2'($urandom);
        bus.cpu_addr      = $urandom;
        checkOutput("lookup_rd_en", 32'(bus.tag_rd_en), 1);
        checkOutput("lookup_index", 32'(bus.tag_rd_index), idx);
        checkOutput("lookup_busy", 32'(bus.cpu_req_ready), 0);

        @(negedge clk);
        checkOutput("compare_rd_en", 32'(bus.tag_rd_en), 0);
        checkOutput("compare_no_resp", 32'(bus.cpu_resp_valid), 0);

        if (hit_way >= 0) begin
            @(negedge clk);
            checkOutput("hit_resp_valid", 32'(bus.cpu_resp_valid), 1);
            checkOutput("hit_resp_hit", 32'(bus.cpu_resp_hit), 1);
            checkOutput("hit_resp_way", 32'(bus.cpu_resp_way), hit_way);
            checkOutput("hit_no_mem", 32'(bus.mem_req_valid), 0);
            return;
        end

        for (int k = 0; k <= rdy_delay; k++) begin
            @(negedge clk);
            checkOutput("memreq_valid", 32'(bus.mem_req_valid), 1);
            checkOutput("memreq_addr", bus.mem_req_addr, a & ~32'hF);
            checkOutput("memreq_busy", 32'(bus.cpu_req_ready), 0);
            bus.mem_req_ready = (k == rdy_delay);
            bus.mem_rsp_valid = stray && (k == 0) && (rdy_delay > 0);
        end

        @(negedge clk);
        bus.mem_req_ready = 1'b0;
        bus.mem_rsp_valid = 1'b0;
        checkOutput("memwait_req_drop", 32'(bus.mem_req_valid), 0);
        checkOutput("memwait_no_wr", 32'(bus.tag_wr_en), 0);

        if (abort) begin
            reset = 1'b0;
            @(negedge clk);
            reset = 1'b1;
            checkOutput("abort_ready", 32'(bus.cpu_req_ready), 1);
            checkOutput("abort_req_drop", 32'(bus.mem_req_valid), 0);
            checkOutput("abort_no_resp", 32'(bus.cpu_resp_valid), 0);
            checkOutput("abort_no_wr", 32'(bus.tag_wr_en), 0);
            rr_model = 0;
            return;
        end

        for (int k = 0; k <= rsp_delay; k++) begin
            if (k > 0) @(negedge clk);
            checkOutput("wait_no_wr", 32'(bus.tag_wr_en), 0);
            checkOutput("wait_no_resp", 32'(bus.cpu_resp_valid), 0);
            bus.mem_rsp_valid = (k == rsp_delay);
        end

        @(negedge clk);
        bus.mem_rsp_valid = 1'b0;
        checkOutput("tagwr_en", 32'(bus.tag_wr_en), 1);
        checkOutput("tagwr_way", 32'(bus.tag_wr_way), victim);
        checkOutput("tagwr_index", 32'(bus.tag_wr_index), idx);
        checkOutput("tagwr_tag", 32'(bus.tag_wr_tag), tg);
        checkOutput("tagwr_no_resp", 32'(bus.cpu_resp_valid), 0);

        @(negedge clk);
        checkOutput("miss_resp_valid", 32'(bus.cpu_resp_valid), 1);
        checkOutput("miss_resp_hit", 32'(bus.cpu_resp_hit), 0);
        checkOutput("miss_resp_way", 32'(bus.cpu_resp_way), victim);
        if (from_rr) rr_model = (rr_model + 1) % n;
    endtask

    initial begin
        logic [151:0] tv;
        logic [31:0]  a;
        logic [31:0]  tg;
        logic [1:0]   m;
        logic [7:0]   vld;

        reset             = 1'b0;
        bus.mode          = '0;
        bus.cpu_req_valid = 1'b0;
        bus.cpu_addr      = '0;
        bus.tag_rd_tag    = '0;
        bus.tag_rd_vld    = '0;
        bus.mem_req_ready = 1'b0;
        bus.mem_rsp_valid = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("rst_ready", 32'(bus.cpu_req_ready), 1);
        checkOutput("rst_resp_valid", 32'(bus.cpu_resp_valid), 0);
        checkOutput("rst_resp_hit", 32'(bus.cpu_resp_hit), 0);
        checkOutput("rst_resp_way", 32'(bus.cpu_resp_way), 0);
        checkOutput("rst_rd_en", 32'(bus.tag_rd_en), 0);
        checkOutput("rst_rd_index", 32'(bus.tag_rd_index), 0);
        checkOutput("rst_wr_en", 32'(bus.tag_wr_en), 0);
        checkOutput("rst_wr_way", 32'(bus.tag_wr_way), 0);
        checkOutput("rst_wr_index", 32'(bus.tag_wr_index), 0);
        checkOutput("rst_wr_tag", 32'(bus.tag_wr_tag), 0);
        checkOutput("rst_mem_valid", 32'(bus.mem_req_valid), 0);
        checkOutput("rst_mem_addr", bus.mem_req_addr, 0);
        reset = 1'b1;

        $display("[TB] directed accesses");
        tv = 152'({$urandom, $urandom, $urandom, $urandom, $urandom});
        tv[18:0] = 19'h01234;
        applyStimulus(2'b00, 32'h1234_5670, tv, 8'h01, 0, 0, 0, 0);

        tv = '0;
        applyStimulus(2'b11, 32'hFFFF_E010, tv, 8'hFF, 0, 0, 0, 0);
        applyStimulus(2'b11, 32'hFFFF_E010, tv, 8'hFF, 0, 0, 0, 0);

        applyStimulus(2'b10, 32'h8000_0000, tv, 8'h0B, 0, 0, 0, 0);
        applyStimulus(2'b10, 32'h8000_0040, tv, 8'hFF, 0, 0, 0, 0);

        tv = '0;
        tv[18:0]  = 19'h02469;
        tv[37:19] = 19'h02469;
        applyStimulus(2'b01, 32'h1234_8000, tv, 8'h03, 0, 0, 0, 0);
        tv = '0;
        tv[19*5 +: 19] = 19'h02469;
        applyStimulus(2'b01, 32'h1234_8000, tv, 8'hFF, 0, 0, 0, 0);

        tv = '0;
        applyStimulus(2'b11, 32'hDEAD_BEE0, tv, 8'hFF, 5, 2, 1, 0);

        $display("[TB] randomized accesses");
        for (int i = 0; i < 60; i++) begin
            m   = 2'($urandom);
            a   = $urandom;
            vld = 8'($urandom);
            tv  = 152'({$urandom, $urandom, $urandom, $urandom, $urandom});
            if ($urandom_range(0, 1) == 1) begin
                int w;
                w  = $urandom_range(0, 7);
                tg = model_tag(m, a);
                tv[19*w +: 19] = tg[18:0];
                if ($urandom_range(0, 3) != 0) vld[w] = 1'b1;
            end
            applyStimulus(m, a, tv, vld, $urandom_range(0, 3), $urandom_range(0, 3),
                          1'($urandom_range(0, 1)), 0);
        end

        $display("[TB] reset during refill");
        tv = '0;
        applyStimulus(2'b11, 32'h4000_0100, tv, 8'hFF, 0, 0, 0, 0);
        if (rr_model == 0) applyStimulus(2'b11, 32'h4000_0200, tv, 8'hFF, 0, 0, 0, 0);
        applyStimulus(2'b11, 32'h4000_0300, tv, 8'hFF, 1, 0, 0, 1);
        applyStimulus(2'b11, 32'h4000_0400, tv, 8'hFF, 0, 1, 0, 0);
        tv[19*3 +: 19] = 19'h20000;
        applyStimulus(2'b11, 32'h4000_0500, tv, 8'hFF, 0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
